// File: rtl/regfile_sb_if.sv
// Bundle of the operand-read, writeback and reservation signals between the
// decode/writeback stages (master) and the register file (slave).
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic                wb_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
        input  rd_data, rd_busy, iss_ready, wb_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
        output rd_data, rd_busy, iss_ready, wb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a pending-write scoreboard.
// Decode reads operands and reserves destinations; writeback writes results
// and releases reservations. Register 0 is hardwired to zero and never busy.
module regfile_sb #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NRD      = 2,
    parameter int              INIT_IDX = 2,
    parameter logic [XLEN-1:0] INIT_VAL = 32'h00000024,
    parameter logic [NREGS-1:0] WP_MASK = '0
) (
    input logic          clk,
    input logic          rstn,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             wb_err_q, wb_err_d;

    logic wr_nz;     // writeback to a real register: frees its reservation
    logic we;        // writeback that actually updates storage
    logic iss_fire;

    assign wr_nz    = bus.wr_en && (bus.wr_addr != '0);
    assign we       = wr_nz && !WP_MASK[bus.wr_addr];

    // A busy register may be re-reserved in the same cycle its writeback lands.
    assign bus.iss_ready = (bus.iss_addr == '0) || !busy_q[bus.iss_addr] ||
                           (bus.wr_en && (bus.wr_addr == bus.iss_addr));
    assign iss_fire = bus.iss_valid && bus.iss_ready;
    assign bus.wb_err = wb_err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata;
        logic            rbusy;
        logic            byp;

        assign ra    = bus.rd_addr[k*AW +: AW];
        assign byp   = we && (ra == bus.wr_addr);
        assign rdata = (ra == '0) ? '0 : (byp ? bus.wr_data : regs_q[ra]);
        assign rbusy = (ra == '0) ? 1'b0 : (byp ? 1'b0 : busy_q[ra]);

        assign bus.rd_data[k*XLEN +: XLEN] = rdata;
        assign bus.rd_busy[k]              = rbusy;
    end

    // Next-state: storage write, release then reserve (set wins), sticky error.
    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (we) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
        if (wr_nz) begin
            busy_d[bus.wr_addr] = 1'b0;
            if (!busy_q[bus.wr_addr]) begin
                wb_err_d = 1'b1;
            end
        end
        if (iss_fire && (bus.iss_addr != '0)) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset discards reservations and loads the init value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= ((i == INIT_IDX) && (i != 0)) ? INIT_VAL : '0;
            end
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: the stimulus process queues the
// expected observable values for each cycle, the monitor compares them while
// the inputs are stable, between clock edges.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int NRD = 2;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_BUSY = 2;
    localparam int K_ISS  = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int          id;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    exp_t sbq[$];

    regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

    regfile_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_IDX(2),
        .INIT_VAL(32'h00000024), .WP_MASK(32'h00000004)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int id, input int kind, input logic [31:0] val);
        exp_t e;
        e.id = id; e.kind = kind; e.val = val;
        sbq.push_back(e);
    endtask

    task automatic exp_rd(input int id, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] busy);
        push(id, K_RD0, d0);
        push(id, K_RD1, d1);
        push(id, K_BUSY, {30'd0, busy});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_valid = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        bus.rd_addr = {a1[AW-1:0], a0[AW-1:0]};
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a[AW-1:0]; bus.wr_data = d;
    endtask

    task automatic iss(input int a, input logic v);
        bus.iss_valid = v; bus.iss_addr = a[AW-1:0];
    endtask

    // Monitor: compare queued expectations mid-cycle while inputs are stable.
    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            #1;
            while (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                case (e.kind)
                    K_RD0:   act = bus.rd_data[31:0];
                    K_RD1:   act = bus.rd_data[63:32];
                    K_BUSY:  act = {30'd0, bus.rd_busy};
                    K_ISS:   act = {31'd0, bus.iss_ready};
                    default: act = {31'd0, bus.wb_err};
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL check%0d kind%0d actual=%h required=%h", e.id, e.kind, act, e.val);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0;
        bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_valid = 1'b0; bus.iss_addr = '0;

        // reset contents visible while held in reset
        step(); rd(2, 3); iss(7, 1'b0);
        exp_rd(1, 32'h24, 32'h0, 2'b00); push(1, K_ISS, 1); push(1, K_ERR, 0);

        step(); rstn = 1'b1; rd(2, 5);
        exp_rd(2, 32'h24, 32'h0, 2'b00);

        // reserve x5, then write it with both ports reading x5 (bypass)
        step(); iss(5, 1'b1); rd(5, 5);
        push(3, K_ISS, 1); exp_rd(3, 0, 0, 2'b00);
        step(); wr(5, 32'hDEADBEEF); rd(5, 5);
        exp_rd(4, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        step(); rd(5, 5);
        exp_rd(5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00); push(5, K_ERR, 0);

        // scoreboard on x7
        step(); iss(7, 1'b1); rd(7, 7);
        push(6, K_ISS, 1); exp_rd(6, 0, 0, 2'b00);
        step(); iss(7, 1'b1); rd(7, 7);
        push(7, K_ISS, 0); exp_rd(7, 0, 0, 2'b11);
        step(); wr(7, 32'h11); iss(7, 1'b1); rd(7, 7);
        push(8, K_ISS, 1); exp_rd(8, 32'h11, 32'h11, 2'b00);
        step(); iss(7, 1'b0); rd(7, 7);
        push(9, K_ISS, 0); exp_rd(9, 32'h11, 32'h11, 2'b11); push(9, K_ERR, 0);
        step(); wr(7, 32'h22); rd(7, 7);
        exp_rd(10, 32'h22, 32'h22, 2'b00);
        step(); rd(7, 7); iss(7, 1'b0);
        exp_rd(11, 32'h22, 32'h22, 2'b00); push(11, K_ISS, 1); push(11, K_ERR, 0);

        // x0 is never written or reserved
        step(); wr(0, 32'hFFFF); iss(0, 1'b1); rd(0, 0);
        exp_rd(12, 0, 0, 2'b00); push(12, K_ISS, 1);
        step(); rd(0, 0); iss(0, 1'b0);
        exp_rd(13, 0, 0, 2'b00); push(13, K_ISS, 1); push(13, K_ERR, 0);

        // write-protected x2: write dropped, reservation freed
        step(); iss(2, 1'b1); rd(2, 2);
        push(14, K_ISS, 1); exp_rd(14, 32'h24, 32'h24, 2'b00);
        step(); iss(2, 1'b0); rd(2, 2);
        push(15, K_ISS, 0); exp_rd(15, 32'h24, 32'h24, 2'b11);
        step(); wr(2, 32'h99); rd(2, 2);
        exp_rd(16, 32'h24, 32'h24, 2'b11);
        step(); rd(2, 2);
        exp_rd(17, 32'h24, 32'h24, 2'b00); push(17, K_ERR, 0); push(17, K_ISS, 1);

        // unreserved writeback raises sticky wb_err, write still lands
        step(); wr(9, 32'hABCD); rd(9, 9);
        exp_rd(18, 32'hABCD, 32'hABCD, 2'b00); push(18, K_ERR, 0);
        step(); rd(9, 2);
        exp_rd(19, 32'hABCD, 32'h24, 2'b00); push(19, K_ERR, 1);
        step(); rd(9, 9);
        push(20, K_ERR, 1);

        // async reset mid-flight with x3/x4 reserved
        step(); iss(3, 1'b1); rd(3, 4);
        push(21, K_ISS, 1);
        step(); iss(4, 1'b1); rd(3, 4);
        push(22, K_ISS, 1); exp_rd(22, 0, 0, 2'b01);
        step(); rd(3, 4); iss(3, 1'b0);
        exp_rd(23, 0, 0, 2'b11); push(23, K_ISS, 0); push(23, K_ERR, 1);
        step(); #2; rstn = 1'b0; rd(3, 4); iss(3, 1'b0);
        exp_rd(24, 0, 0, 2'b00); push(24, K_ISS, 1); push(24, K_ERR, 0);
        step(); rd(2, 9);
        exp_rd(25, 32'h24, 0, 2'b00);
        step(); rstn = 1'b1; iss(3, 1'b1); rd(3, 5);
        push(26, K_ISS, 1); exp_rd(26, 0, 0, 2'b00);
        step(); rd(3, 5); iss(3, 1'b0);
        exp_rd(27, 0, 0, 2'b01); push(27, K_ISS, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
